// File: rtl/d2d_pkg.sv
// Shared link-level constants for both ends of the die-to-die credit link.
package d2d_pkg;

  localparam int D2D_CREDITS = 8;
  localparam int D2D_DATA_W  = 32;

  // Counter width that holds 0..depth inclusive.
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int D2D_CNT_W = calc_cnt_w(D2D_CREDITS);

endpackage

// File: rtl/d2d_rx_fifo.sv
// Circular first-word-fall-through FIFO: storage, pointers and entry count.
module d2d_rx_fifo
  import d2d_pkg::*;
#(
  parameter int DEPTH  = D2D_CREDITS,
  parameter int DATA_W = D2D_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic [calc_cnt_w(DEPTH)-1:0] count
);

  localparam int CNT_W = calc_cnt_w(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  cnt;

  // Wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and count update; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage is not reset; contents only matter behind a valid count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/d2d_rx_credit_buffer.sv
// Receive-side credit buffer: FIFO for link flits plus credit return and
// overflow detection toward the transmit side.
module d2d_rx_credit_buffer
  import d2d_pkg::*;
#(
  parameter int CREDITS = D2D_CREDITS,
  parameter int DATA_W  = D2D_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [DATA_W-1:0]          rx_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  input  logic                       credit_hold,
  output logic                       credit_ret,
  output logic [$clog2(CREDITS):0]   occupancy,
  output logic                       ovf_err
);

  localparam int CNT_W = calc_cnt_w(CREDITS);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] avail;
  logic             full, push, pop;

  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign full      = (count == CNT_W'(CREDITS));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = rx_valid && (!full || pop);
  assign avail     = pend + {{(CNT_W-1){1'b0}}, pop};
  assign occupancy = count;

  d2d_rx_fifo #(
    .DEPTH  (CREDITS),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (out_data),
    .count (count)
  );

  // Return one freed credit per cycle; backlog accumulates while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_ret <= 1'b0;
      pend       <= '0;
    end else if (!credit_hold && (avail != '0)) begin
      credit_ret <= 1'b1;
      pend       <= avail - 1'b1;
    end else begin
      credit_ret <= 1'b0;
      pend       <= avail;
    end
  end

  // Sticky flag: a flit arrived with every slot taken and nothing leaving.
  always_ff @(posedge clk) begin
    if (rst)                           ovf_err <= 1'b0;
    else if (rx_valid && full && !pop) ovf_err <= 1'b1;
  end

endmodule

// File: doc/d2d_rx_credit_buffer.md
D2D_RX_CREDIT_BUFFER -- requirements
Module: d2d_rx_credit_buffer

Interface
REQ-001 Parameter CREDITS, default 8: buffer depth; equals the credit count the transmit side starts with after reset.
REQ-002 Parameter DATA_W, default 32: flit payload width.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rx_valid  in  1  flit arriving from the link this cycle; there is no backpressure path to the link.
REQ-006 rx_data  in  DATA_W  flit payload, qualified by rx_valid.
REQ-007 out_valid  out  1  head entry available to the consumer.
REQ-008 out_data  out  DATA_W  head entry payload.
REQ-009 out_ready  in  1  consumer accepts the head entry.
REQ-010 credit_hold  in  1  suppress credit return (link retrain/pause); freed credits accumulate while high.
REQ-011 credit_ret  out  1  one-cycle pulse; each pulse returns exactly one credit to the transmit side.
REQ-012 occupancy  out  $clog2(CREDITS)+1  current number of stored entries.
REQ-013 ovf_err  out  1  sticky protocol error: a flit arrived with no free slot.

Function
REQ-014 Storage SHALL be a CREDITS-entry circular FIFO with first-word fall-through behaviour; read and write pointers wrap from CREDITS-1 to 0.
REQ-015 push = rx_valid and (count < CREDITS, or pop in the same cycle); pop = out_valid and out_ready.
REQ-016 out_valid SHALL equal (count != 0), decoded from registered state only; out_data SHALL equal mem[rd_ptr].
REQ-017 Latency: a flit pushed in cycle N SHALL appear on out_valid/out_data in cycle N+1.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; this also applies at count == CREDITS, where the flit is accepted.
REQ-019 Simultaneous push and pop with count == 0 is impossible (out_valid low); the pushed flit SHALL be visible in the next cycle.
REQ-020 rx_valid with count == CREDITS and no pop SHALL drop the flit, leave the FIFO unchanged, and set ovf_err.
REQ-021 ovf_err SHALL hold until rst.
REQ-022 Credit return uses a pending counter pend, width $clog2(CREDITS)+1; compute avail = pend + pop.
REQ-023 If credit_hold == 0 and avail > 0: credit_ret <= 1 and pend <= avail - 1.
REQ-024 Otherwise: credit_ret <= 0 and pend <= avail.
REQ-025 Credit latency: a pop in cycle N with hold low and pend == 0 SHALL produce credit_ret high in cycle N+1.
REQ-026 At most one credit is returned per cycle, so a backlog drains at one per cycle once hold falls.
REQ-027 Invariant: count + pend + (credits outstanding at the transmit side) == CREDITS; pend SHALL never exceed CREDITS.
REQ-028 occupancy SHALL equal count and SHALL be registered.

Reset
REQ-029 On rst high at a clock edge, the following SHALL all clear to 0: read/write pointers, count, pend, credit_ret, ovf_err, out_valid, occupancy.
REQ-030 Storage contents are not reset; out_data is don't-care while out_valid is low.
REQ-031 rst asserted mid-operation SHALL discard stored flits and pending credits without emitting any credit_ret pulse; the transmit side is reset together with this block.
REQ-032 Inputs are ignored in any cycle where rst is high.

Structure
REQ-033 Shared package d2d_pkg SHALL hold the CREDITS and DATA_W defaults and a derived CNT_W = $clog2(CREDITS)+1 constant used by both link ends.
REQ-034 FIFO storage and pointers SHALL be one sub-module, d2d_rx_fifo, with push/pop/count ports.
REQ-035 The credit-return counter, overflow detection, and credit_ret register SHALL live in the top module.

Verification
REQ-036 Reset, then one flit 0xA5A5_0001 with out_ready=1 -> out_valid in cycle +1, pop that cycle, credit_ret pulse in cycle +2, occupancy returns to 0.
REQ-037 Fill 8 flits with out_ready=0 -> occupancy=8, no credit_ret, ovf_err=0; a 9th flit -> dropped, ovf_err=1 until rst, FIFO contents unchanged.
REQ-038 count=8 with rx_valid and out_ready both high for 4 cycles -> all 4 new flits accepted, occupancy stays 8, ovf_err stays 0, 4 credit_ret pulses, data order preserved.
REQ-039 credit_hold=1 while popping 5 entries -> no credit_ret; release hold -> exactly 5 consecutive credit_ret pulses, then low.
REQ-040 Write 12 flits with interleaved pops (pointer wrap) -> output sequence identical to input sequence, total credit_ret pulses = 12.
REQ-041 rst asserted with occupancy=3 and pend=2 -> next cycle out_valid=0, occupancy=0, no credit_ret pulses afterwards.
